// File: rtl/mxint8_block_quantizer_pkg.sv
// Shared constants and types for the FP32-to-MXINT8 block quantizer.
package mxint8_block_quantizer_pkg;

    localparam int unsigned FP32_SIGN_BIT = 31;
    localparam int unsigned FP32_EXP_MSB  = 30;
    localparam int unsigned FP32_EXP_LSB  = 23;
    localparam int unsigned FP32_MAN_MSB  = 22;
    localparam logic [7:0]  FP32_BIAS     = 8'd127;

    localparam logic [7:0]  SCALE_NAN     = 8'hFF;
    localparam logic [7:0]  INT8_SAT      = 8'd127;

    typedef enum logic [1:0] {FILL, CONV, HOLD} state_t;

endpackage

// File: rtl/mxint8_elem_quant.sv
// Combinational float32 to INT8 (1.6 fixed point) converter against a shared exponent.
module mxint8_elem_quant
    import mxint8_block_quantizer_pkg::*;
(
    input  logic [31:0] float32,
    input  logic [7:0]  max_exp,
    output logic [7:0]  elem
);

    logic        sign;
    logic [7:0]  exp_field;
    logic [23:0] sig;
    logic [7:0]  d;
    logic [8:0]  shamt;
    logic [7:0]  pre;
    logic [7:0]  rounded;
    logic [6:0]  mag;

    always_comb begin
        sign      = float32[FP32_SIGN_BIT];
        exp_field = float32[FP32_EXP_MSB:FP32_EXP_LSB];
        sig       = {1'b1, float32[FP32_MAN_MSB:0]};
        d         = max_exp - exp_field;
        // Shift one bit less than the final alignment so the round bit lands in pre[0].
        shamt     = 9'd16 + {1'b0, d};
        pre       = 8'(sig >> shamt);
        rounded   = 8'((9'({1'b0, pre}) + 9'd1) >> 1);
        if (exp_field == 8'd0 || d >= 8'd24) begin
            rounded = 8'd0;
        end
        mag  = (rounded > INT8_SAT) ? INT8_SAT[6:0] : rounded[6:0];
        elem = sign ? (8'd0 - {1'b0, mag}) : {1'b0, mag};
    end

endmodule

// File: rtl/mxint8_block_quantizer.sv
// Streaming FP32-to-MXINT8 encoder: buffers a block, derives the E8M0 scale,
// then quantizes one element per cycle and presents the block as one beat.
module mxint8_block_quantizer
    import mxint8_block_quantizer_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE           = 32,
    parameter int unsigned SCALE_WIDTH          = 8,
    parameter int unsigned MXINT8_ELEMENT_WIDTH = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [31:0]                     i_float32,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [SCALE_WIDTH-1:0]          o_scale,
    output logic [MXINT8_ELEMENT_WIDTH-1:0] o_mxint8_elements [BLOCK_SIZE],
    output logic                            o_nan
);

    localparam int unsigned     CNT_W    = $clog2(BLOCK_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_SIZE - 1);

    state_t                          state;
    logic [CNT_W-1:0]                cnt;
    logic [31:0]                     fbuf [BLOCK_SIZE];
    logic [7:0]                      max_exp;
    logic                            nan_flag;
    logic [MXINT8_ELEMENT_WIDTH-1:0] q_elem;
    logic [7:0]                      in_exp;
    logic                            in_fire;

    assign in_exp  = i_float32[FP32_EXP_MSB:FP32_EXP_LSB];
    assign in_fire = i_valid && o_ready;

    mxint8_elem_quant u_elem_quant (
        .float32 (fbuf[cnt]),
        .max_exp (max_exp),
        .elem    (q_elem)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= FILL;
            cnt      <= '0;
            max_exp  <= 8'd0;
            nan_flag <= 1'b0;
            o_ready  <= 1'b0;
            o_valid  <= 1'b0;
            o_scale  <= '0;
            o_nan    <= 1'b0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                o_mxint8_elements[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    o_ready <= 1'b1;
                    if (in_fire) begin
                        fbuf[cnt] <= i_float32;
                        cnt       <= cnt + 1'b1;
                        // Zeros and subnormals never set the shared exponent.
                        if (in_exp != 8'd0 && in_exp > max_exp) begin
                            max_exp <= in_exp;
                        end
                        if (in_exp == 8'hFF) begin
                            nan_flag <= 1'b1;
                        end
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            o_ready <= 1'b0;
                            state   <= CONV;
                        end
                    end
                end
                CONV: begin
                    o_mxint8_elements[cnt] <= nan_flag ? '0 : q_elem;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        o_scale <= nan_flag ? SCALE_NAN : max_exp;
                        o_nan   <= nan_flag;
                        o_valid <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        o_valid  <= 1'b0;
                        o_ready  <= 1'b1;
                        max_exp  <= 8'd0;
                        nan_flag <= 1'b0;
                        cnt      <= '0;
                        state    <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_mxint8_block_quantizer.sv
// Directed bench for mxint8_block_quantizer with a real-arithmetic reference model.
module tb_mxint8_block_quantizer;
    import mxint8_block_quantizer_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_float32;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_scale;
    logic [7:0]  elems [32];
    logic        o_nan;

    typedef struct packed {
        logic [7:0]       scale;
        logic             nan;
        logic [31:0][7:0] el;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] blk [32];
    int          passed = 0;
    int          total  = 0;
    int          fails  = 0;

    always #5 i_clk = ~i_clk;

    mxint8_block_quantizer dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_float32         (i_float32),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_scale           (o_scale),
        .o_mxint8_elements (elems),
        .o_nan             (o_nan)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic exp_t model();
        exp_t r;
        int   x = 0;
        bit   nan = 0;
        int   e;
        int   mag;
        real  v;
        for (int i = 0; i < 32; i++) begin
            e = int'(blk[i][30:23]);
            if (e == 255) nan = 1;
            else if (e != 0 && e > x) x = e;
        end
        r.scale = nan ? 8'hFF : 8'(x);
        r.nan   = nan;
        for (int i = 0; i < 32; i++) begin
            e = int'(blk[i][30:23]);
            if (nan || e == 0) begin
                mag = 0;
            end else begin
                v   = (1.0 + real'(blk[i][22:0]) / 8388608.0) * (2.0 ** (e - x)) * 64.0;
                mag = int'($floor(v + 0.5));
                if (mag > 127) mag = 127;
            end
            r.el[i] = blk[i][31] ? 8'(-mag) : 8'(mag);
        end
        return r;
    endfunction

    task automatic fill_blk(input logic [31:0] val);
        for (int i = 0; i < 32; i++) blk[i] = val;
    endtask

    task automatic send_block();
        int n;
        sbq.push_back(model());
        for (int i = 0; i < 32; i++) begin
            i_valid   = 1'b1;
            i_float32 = blk[i];
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        check("ready_low_conv", {31'd0, o_ready}, 32'd0);
        // n counts cycles since the edge that took the last element
        n = 1;
        while (!o_valid && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check("latency", n, 33);
    endtask

    task automatic drain(input int bp);
        exp_t w;
        check("sb_size", sbq.size(), 1);
        if (sbq.size() == 0) return;
        w = sbq.pop_front();
        check("valid", {31'd0, o_valid}, 32'd1);
        check("scale", {24'd0, o_scale}, {24'd0, w.scale});
        check("nan", {31'd0, o_nan}, {31'd0, w.nan});
        for (int i = 0; i < 32; i++) begin
            check($sformatf("elem%0d", i), {24'd0, elems[i]}, {24'd0, w.el[i]});
        end
        for (int c = 0; c < bp; c++) begin
            @(negedge i_clk);
            check("bp_valid", {31'd0, o_valid}, 32'd1);
            check("bp_ready", {31'd0, o_ready}, 32'd0);
            check("bp_scale", {24'd0, o_scale}, {24'd0, w.scale});
            check("bp_nan", {31'd0, o_nan}, {31'd0, w.nan});
            check("bp_elem0", {24'd0, elems[0]}, {24'd0, w.el[0]});
            check("bp_elem31", {24'd0, elems[31]}, {24'd0, w.el[31]});
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        check("valid_drop", {31'd0, o_valid}, 32'd0);
        check("ready_back", {31'd0, o_ready}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        check({tag, "_ready"}, {31'd0, o_ready}, 32'd0);
        check({tag, "_scale"}, {24'd0, o_scale}, 32'd0);
        check({tag, "_nan"}, {31'd0, o_nan}, 32'd0);
        check({tag, "_elem0"}, {24'd0, elems[0]}, 32'd0);
        check({tag, "_elem1"}, {24'd0, elems[1]}, 32'd0);
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_float32 = 32'd0;
        repeat (3) @(negedge i_clk);
        check_reset_values("rst");
        i_rst = 1'b0;
        @(negedge i_clk);
        check("ready_after_rst", {31'd0, o_ready}, 32'd1);

        // Uniform 1.0
        fill_blk(32'h3F800000);
        send_block();
        check("uni_scale", {24'd0, o_scale}, {24'd0, FP32_BIAS});
        check("uni_elem5", {24'd0, elems[5]}, 32'h40);
        drain(0);

        // Mixed: 3.0, -1.0, then 1.0
        fill_blk(32'h3F800000);
        blk[0] = 32'h40400000;
        blk[1] = 32'hBF800000;
        send_block();
        check("mix_scale", {24'd0, o_scale}, 32'd128);
        check("mix_elem0", {24'd0, elems[0]}, 32'h60);
        check("mix_elem1", {24'd0, elems[1]}, 32'hE0);
        check("mix_elem2", {24'd0, elems[2]}, 32'h20);
        drain(0);

        // Reset after 10 inputs discards the partial block
        fill_blk(32'h3F800000);
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1;
            i_float32 = blk[i];
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        check_reset_values("midrst");
        i_rst = 1'b0;
        @(negedge i_clk);
        check("ready_after_midrst", {31'd0, o_ready}, 32'd1);

        // Fresh random block (normal values only)
        for (int i = 0; i < 32; i++) begin
            blk[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
        end
        send_block();
        drain(0);

        // Rounding and saturation, with backpressure in HOLD
        fill_blk(32'h3F800000);
        blk[0] = 32'h3FFFFFFF;
        blk[1] = 32'hBFFFFFFF;
        blk[2] = 32'h3C000000;
        blk[3] = 32'h3B800000;
        send_block();
        check("rnd_scale", {24'd0, o_scale}, 32'd127);
        check("rnd_sat_pos", {24'd0, elems[0]}, 32'h7F);
        check("rnd_sat_neg", {24'd0, elems[1]}, 32'h81);
        check("rnd_tie", {24'd0, elems[2]}, 32'h01);
        check("rnd_below", {24'd0, elems[3]}, 32'h00);
        drain(5);

        // NaN among 1.0s
        fill_blk(32'h3F800000);
        blk[7] = 32'h7FC00000;
        send_block();
        check("nan_scale", {24'd0, o_scale}, {24'd0, SCALE_NAN});
        check("nan_flag", {31'd0, o_nan}, 32'd1);
        check("nan_elem0", {24'd0, elems[0]}, 32'h00);
        drain(0);

        // All +0.0
        fill_blk(32'h00000000);
        send_block();
        check("zero_scale", {24'd0, o_scale}, 32'd0);
        drain(0);

        // One subnormal among zeros
        fill_blk(32'h00000000);
        blk[4] = 32'h00000001;
        send_block();
        check("sub_scale", {24'd0, o_scale}, 32'd0);
        check("sub_elem4", {24'd0, elems[4]}, 32'd0);
        drain(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
